// File: rtl/wb_master_if.sv
// Command/response handshake plus Wishbone master-side bus, bundled for wb_master.
// The master modport is the wb_master view; slave is the command source / bus slave view.
interface wb_master_if #(
    parameter int unsigned WB_DATA_WIDTH = 8,
    parameter int unsigned WB_ADDR_WIDTH = 2
);
    // command channel
    logic                     cmd_valid_i;
    logic                     cmd_ready_o;
    logic                     cmd_we_i;
    logic [WB_ADDR_WIDTH-1:0] cmd_adr_i;
    logic [WB_DATA_WIDTH-1:0] cmd_dat_i;

    // response channel
    logic                     rsp_valid_o;
    logic                     rsp_ready_i;
    logic [WB_DATA_WIDTH-1:0] rsp_dat_o;
    logic                     rsp_err_o;

    // Wishbone bus
    logic                     cyc_o;
    logic                     stb_o;
    logic                     we_o;
    logic [WB_ADDR_WIDTH-1:0] adr_o;
    logic [WB_DATA_WIDTH-1:0] dat_o;
    logic [WB_DATA_WIDTH-1:0] dat_i;
    logic                     ack_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i,
        input  rsp_ready_i,
        input  dat_i, ack_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o,
        output cyc_o, stb_o, we_o, adr_o, dat_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i,
        output rsp_ready_i,
        output dat_i, ack_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  cyc_o, stb_o, we_o, adr_o, dat_o
    );
endinterface

// File: rtl/wb_master.sv
// Single-outstanding Wishbone classic master: one command in, one bus cycle, one response out.
// A bus cycle that sees no ack within TIMEOUT_CYCLES ends with an error response.
module wb_master #(
    parameter int unsigned WB_DATA_WIDTH  = 8,
    parameter int unsigned WB_ADDR_WIDTH  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    wb_master_if.master  bus
);

    localparam int unsigned TMO_W = 8;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                   state;
    logic [TMO_W-1:0]         tmo_cnt;

    logic                     cyc_q;
    logic                     stb_q;
    logic                     we_q;
    logic [WB_ADDR_WIDTH-1:0] adr_q;
    logic [WB_DATA_WIDTH-1:0] dat_q;
    logic                     rsp_valid_q;
    logic                     rsp_err_q;
    logic [WB_DATA_WIDTH-1:0] rsp_dat_q;

    // Ready is a pure state decode so an upstream source can never form a comb loop through it.
    assign bus.cmd_ready_o = (state == IDLE);

    assign bus.cyc_o       = cyc_q;
    assign bus.stb_o       = stb_q;
    assign bus.we_o        = we_q;
    assign bus.adr_o       = adr_q;
    assign bus.dat_o       = dat_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_dat_o   = rsp_dat_q;

    // Transaction FSM; ack_i/dat_i are only looked at in BUS, so late acks are harmless.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid_i) begin
                        we_q    <= bus.cmd_we_i;
                        adr_q   <= bus.cmd_adr_i;
                        dat_q   <= bus.cmd_dat_i;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= BUS;
                    end
                end

                BUS: begin
                    if (bus.ack_i) begin
                        // ack takes priority even on the last timeout cycle
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        rsp_dat_q   <= we_q ? '0 : bus.dat_i;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        rsp_dat_q   <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                RESP: begin
                    if (bus.rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    cyc_q       <= 1'b0;
                    stb_q       <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master.sv
// Directed self-checking bench for wb_master: write, read, timeout, ack-on-last-cycle,
// back-to-back commands with a registered-ack slave, and asynchronous reset behaviour.
module tb_wb_master;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 2;

    logic clk;
    logic rst;

    wb_master_if #(.WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW)) bus ();

    wb_master #(
        .WB_DATA_WIDTH (DW),
        .WB_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: 0 = never ack, 1 = registered ack (also leaves a stale ack after stb falls),
    // 2 = combinational ack on the 16th strobe cycle, 3 = ack stuck high.
    int unsigned   slv_mode;
    logic          dat_by_adr;
    logic [DW-1:0] slv_dat;
    logic          ack_reg;
    logic [7:0]    stb_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_reg <= 1'b0;
            stb_cnt <= 8'd0;
        end else begin
            ack_reg <= bus.cyc_o & bus.stb_o;
            stb_cnt <= bus.stb_o ? stb_cnt + 8'd1 : 8'd0;
        end
    end

    assign bus.ack_i = (slv_mode == 1) ? ack_reg :
                       (slv_mode == 2) ? (bus.stb_o && stb_cnt == 8'd15) :
                       (slv_mode == 3);
    assign bus.dat_i = dat_by_adr ? (8'hC0 | DW'(bus.adr_o)) : slv_dat;

    int n_assert;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one command at a negedge; returns at the next negedge, after acceptance.
    task automatic issue(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        bus.cmd_we_i    = we;
        bus.cmd_adr_i   = adr;
        bus.cmd_dat_i   = dat;
        bus.cmd_valid_i = 1'b1;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
    endtask

    // Count strobe cycles until a response shows up (bounded).
    task automatic run_to_rsp(output int stb_cycles);
        stb_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.stb_o) stb_cycles++;
            if (bus.rsp_valid_o) break;
            @(negedge clk);
        end
    endtask

    task automatic consume();
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
    endtask

    logic [AW-1:0] b2b_adr [3];
    logic          b2b_we  [3];
    logic [DW-1:0] b2b_dat [3];
    logic [DW-1:0] b2b_exp [3];

    initial begin
        int n;
        int idx;
        int nrsp;
        int lowrun;
        logic pend;
        logic seen;
        logic prev_stb;

        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        slv_mode = 0;
        dat_by_adr = 1'b0;
        slv_dat  = 8'h00;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_adr_i   = '0;
        bus.cmd_dat_i   = '0;
        bus.rsp_ready_i = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_cyc", 32'(bus.cyc_o), 0);
        chk("rst_stb", 32'(bus.stb_o), 0);
        chk("rst_we", 32'(bus.we_o), 0);
        chk("rst_adr", 32'(bus.adr_o), 0);
        chk("rst_dat", 32'(bus.dat_o), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 0);
        chk("rst_rsp_err", 32'(bus.rsp_err_o), 0);
        chk("rst_rsp_dat", 32'(bus.rsp_dat_o), 0);
        chk("rst_ready", 32'(bus.cmd_ready_o), 1);
        rst = 1'b0;
        @(negedge clk);

        // write with registered-ack slave: stb for 2 cycles, response on the 3rd
        slv_mode = 1;
        issue(1'b1, 2'd2, 8'hA5);
        chk("wr_stb_c1", 32'(bus.stb_o), 1);
        chk("wr_cyc_c1", 32'(bus.cyc_o), 1);
        chk("wr_we_c1", 32'(bus.we_o), 1);
        chk("wr_adr_c1", 32'(bus.adr_o), 2);
        chk("wr_dat_c1", 32'(bus.dat_o), 32'hA5);
        chk("wr_ready_busy", 32'(bus.cmd_ready_o), 0);
        @(negedge clk);
        chk("wr_stb_c2", 32'(bus.stb_o), 1);
        chk("wr_we_c2", 32'(bus.we_o), 1);
        chk("wr_adr_c2", 32'(bus.adr_o), 2);
        chk("wr_dat_c2", 32'(bus.dat_o), 32'hA5);
        chk("wr_rsp_early", 32'(bus.rsp_valid_o), 0);
        @(negedge clk);
        chk("wr_stb_c3", 32'(bus.stb_o), 0);
        chk("wr_cyc_c3", 32'(bus.cyc_o), 0);
        chk("wr_rsp_valid", 32'(bus.rsp_valid_o), 1);
        chk("wr_rsp_err", 32'(bus.rsp_err_o), 0);
        chk("wr_rsp_dat", 32'(bus.rsp_dat_o), 0);
        chk("wr_ready_resp", 32'(bus.cmd_ready_o), 0);
        consume();
        chk("wr_rsp_clr", 32'(bus.rsp_valid_o), 0);
        chk("wr_ready_idle", 32'(bus.cmd_ready_o), 1);

        // read, response held while ready is low
        slv_dat = 8'h3C;
        issue(1'b0, 2'd1, 8'hFF);
        run_to_rsp(n);
        chk("rd_stb_cycles", 32'(n), 2);
        chk("rd_rsp_valid", 32'(bus.rsp_valid_o), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rd_hold_valid", 32'(bus.rsp_valid_o), 1);
            chk("rd_hold_dat", 32'(bus.rsp_dat_o), 32'h3C);
            chk("rd_hold_err", 32'(bus.rsp_err_o), 0);
            chk("rd_hold_stb", 32'(bus.stb_o), 0);
        end
        consume();
        chk("rd_rsp_clr", 32'(bus.rsp_valid_o), 0);
        chk("rd_keep_adr", 32'(bus.adr_o), 1);
        chk("rd_keep_we", 32'(bus.we_o), 0);

        // timeout with no ack
        slv_mode = 0;
        issue(1'b1, 2'd3, 8'h11);
        run_to_rsp(n);
        chk("tmo_stb_cycles", 32'(n), 16);
        chk("tmo_rsp_valid", 32'(bus.rsp_valid_o), 1);
        chk("tmo_rsp_err", 32'(bus.rsp_err_o), 1);
        chk("tmo_rsp_dat", 32'(bus.rsp_dat_o), 0);
        chk("tmo_cyc", 32'(bus.cyc_o), 0);
        consume();
        chk("tmo_rsp_clr", 32'(bus.rsp_valid_o), 0);

        // ack on the 16th cycle beats the timeout
        slv_mode = 2;
        slv_dat  = 8'h5A;
        issue(1'b0, 2'd0, 8'h00);
        run_to_rsp(n);
        chk("ack16_stb_cycles", 32'(n), 16);
        chk("ack16_rsp_valid", 32'(bus.rsp_valid_o), 1);
        chk("ack16_rsp_err", 32'(bus.rsp_err_o), 0);
        chk("ack16_rsp_dat", 32'(bus.rsp_dat_o), 32'h5A);
        consume();

        // ack while idle has no effect
        slv_mode = 3;
        repeat (3) @(negedge clk);
        chk("idle_ack_rsp", 32'(bus.rsp_valid_o), 0);
        chk("idle_ack_cyc", 32'(bus.cyc_o), 0);
        chk("idle_ack_ready", 32'(bus.cmd_ready_o), 1);
        slv_mode = 0;

        // back-to-back: valid held high, three commands, ready always high
        b2b_adr = '{2'd0, 2'd3, 2'd1};
        b2b_we  = '{1'b0, 1'b0, 1'b1};
        b2b_dat = '{8'h00, 8'h00, 8'h77};
        b2b_exp = '{8'hC0, 8'hC3, 8'h00};
        slv_mode   = 1;
        dat_by_adr = 1'b1;
        bus.rsp_ready_i = 1'b1;
        idx = 0; nrsp = 0; lowrun = 0; seen = 1'b0; prev_stb = 1'b0;
        bus.cmd_we_i    = b2b_we[0];
        bus.cmd_adr_i   = b2b_adr[0];
        bus.cmd_dat_i   = b2b_dat[0];
        bus.cmd_valid_i = 1'b1;
        pend = bus.cmd_ready_o;
        for (int c = 0; c < 60 && nrsp < 3; c++) begin
            @(negedge clk);
            if (bus.stb_o && !prev_stb && seen)
                chk("b2b_gap", 32'(lowrun >= 1), 1);
            if (bus.stb_o) begin
                seen = 1'b1;
                lowrun = 0;
            end else begin
                lowrun++;
            end
            prev_stb = bus.stb_o;
            if (bus.rsp_valid_o) begin
                chk("b2b_rsp_dat", 32'(bus.rsp_dat_o), 32'(b2b_exp[nrsp]));
                chk("b2b_rsp_err", 32'(bus.rsp_err_o), 0);
                nrsp++;
            end
            if (pend) begin
                idx++;
                pend = 1'b0;
                if (idx < 3) begin
                    bus.cmd_we_i  = b2b_we[idx];
                    bus.cmd_adr_i = b2b_adr[idx];
                    bus.cmd_dat_i = b2b_dat[idx];
                end else begin
                    bus.cmd_valid_i = 1'b0;
                end
            end
            if (bus.cmd_valid_i && bus.cmd_ready_o) pend = 1'b1;
        end
        chk("b2b_rsp_count", 32'(nrsp), 3);
        repeat (3) @(negedge clk);
        chk("b2b_no_extra_rsp", 32'(bus.rsp_valid_o), 0);
        chk("b2b_idle_cyc", 32'(bus.cyc_o), 0);
        bus.rsp_ready_i = 1'b0;
        bus.cmd_valid_i = 1'b0;
        dat_by_adr = 1'b0;

        // reset mid-bus drops cyc/stb without a clock edge
        slv_mode = 0;
        issue(1'b1, 2'd2, 8'h99);
        chk("mid_stb_before", 32'(bus.stb_o), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_stb", 32'(bus.stb_o), 0);
        chk("mid_rst_cyc", 32'(bus.cyc_o), 0);
        chk("mid_rst_ready", 32'(bus.cmd_ready_o), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        slv_mode = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 32'(bus.rsp_valid_o), 0);
            chk("post_rst_ready", 32'(bus.cmd_ready_o), 1);
        end

        // command accepted on the first edge after reset release
        rst = 1'b1;
        @(negedge clk);
        bus.cmd_we_i    = 1'b0;
        bus.cmd_adr_i   = 2'd3;
        bus.cmd_dat_i   = 8'h00;
        bus.cmd_valid_i = 1'b1;
        slv_dat = 8'hE7;
        rst = 1'b0;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        chk("first_edge_stb", 32'(bus.stb_o), 1);
        chk("first_edge_adr", 32'(bus.adr_o), 3);
        run_to_rsp(n);
        chk("first_edge_rsp_dat", 32'(bus.rsp_dat_o), 32'hE7);
        chk("first_edge_rsp_valid", 32'(bus.rsp_valid_o), 1);
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
